// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined datapath. This slice holds the fetch
// sequencer additions: the fetch FSM state encoding and the default width of
// the optional fetch performance counters.
//
// Configuration macro: FETCH_PERF_EN (FETCH_CNT_W is only used when it is set)
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    // Default width of the fetch performance counters
    localparam int FETCH_CNT_W = 32;

    // FETCH  : normal sequencing, one outstanding icache read
    // SQUASH : a redirect happened while a read to the old address was in
    //          flight; the next returning instruction must be thrown away
    // HALT   : processor stopped, only reset leaves this state
    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        SQUASH = 2'b01,
        HALT   = 2'b10
    } fetch_state_t;

    // A redirect is any EX-stage control transfer
    function automatic logic is_redirect(input logic br_taken, input logic jump_i);
        return br_taken | jump_i;
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// -----------------------------------------------------------------------------
// fetch_perf_ctr
// Free-running event counter that wraps modulo 2^CNT_W. Counts one per clock
// while en_i is high and is cleared by the asynchronous active-low reset.
//
// Ports
//   CLK    in   1      clock, posedge
//   nRST   in   1      asynchronous active-low clear
//   en_i   in   1      count enable
//   cnt_o  out  CNT_W  current count
//
// Configuration macro: FETCH_PERF_EN (only instantiated when it is defined)
// -----------------------------------------------------------------------------
module fetch_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment when enabled; natural overflow of the adder gives the wrap
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Sequencer for the program counter and the instruction fetch port. Arbitrates
// between icache wait (ihit), hazard stall, EX-stage redirect (branch/jump) and
// halt, and squashes the fetch that was in flight when a redirect happened.
//
// Ports
//   CLK         in   1      system clock, posedge
//   nRST        in   1      asynchronous active-low reset
//   ihit        in   1      icache returned an instruction this cycle
//   stall_i     in   1      hazard unit: hold PC and IF/ID
//   br_taken    in   1      EX-stage branch resolved taken
//   jump_i      in   1      EX-stage J/JAL
//   halt_i      in   1      HALT opcode reached EX
//   pcEN        out  1      PC load enable
//   branchmux   out  1      PC selects branch target
//   jumpmux     out  1      PC selects jump target
//   imemREN     out  1      instruction read request
//   ifid_en     out  1      IF/ID latch enable
//   ifid_flush  out  1      IF/ID loads a bubble
//   halted      out  1      processor halted (sticky until reset)
//   miss_cnt    out  CNT_W  FETCH cycles waiting on the icache (FETCH_PERF_EN)
//   squash_cnt  out  CNT_W  fetches discarded in SQUASH (FETCH_PERF_EN)
//
// Configuration macro: FETCH_PERF_EN adds the CNT_W parameter, the two
// counter ports and two fetch_perf_ctr instances.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import cpu_types_pkg::*;
`ifdef FETCH_PERF_EN
#(
    parameter int CNT_W = FETCH_CNT_W
)
`endif
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             stall_i,
    input  logic             br_taken,
    input  logic             jump_i,
    input  logic             halt_i,
    output logic             pcEN,
    output logic             branchmux,
    output logic             jumpmux,
    output logic             imemREN,
    output logic             ifid_en,
    output logic             ifid_flush,
`ifdef FETCH_PERF_EN
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] squash_cnt,
`endif
    output logic             halted
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         run_q;
    logic         redirect;

    assign redirect = is_redirect(br_taken, jump_i);

    // State register plus the run flag. run_q keeps every output quiet for the
    // first cycle after reset release so the PC and icache see a clean start.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state and output decode. Everything except halted is gated by
    // run_q, and the FSM holds until run_q is set. halt_i wins over every
    // other input; a redirect wins over stall_i and over a returning ihit.
    // When branch and jump fire together the jump target is selected.
    always_comb begin
        state_d    = state_q;
        pcEN       = 1'b0;
        branchmux  = 1'b0;
        jumpmux    = 1'b0;
        imemREN    = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;

        if (run_q) begin
            unique case (state_q)
                FETCH: begin
                    imemREN = 1'b1;
                    if (halt_i) begin
                        state_d = HALT;
                    end else begin
                        pcEN       = (ihit & ~stall_i) | redirect;
                        ifid_en    = ihit & ~stall_i & ~redirect;
                        ifid_flush = redirect;
                        jumpmux    = jump_i;
                        branchmux  = br_taken & ~jump_i;
                        // Old-address read still outstanding: drop its data
                        if (redirect && !ihit) begin
                            state_d = SQUASH;
                        end
                    end
                end

                SQUASH: begin
                    imemREN = 1'b1;
                    if (halt_i) begin
                        state_d = HALT;
                    end else if (redirect) begin
                        // New target loads, but a stale read is still pending
                        pcEN       = 1'b1;
                        ifid_flush = 1'b1;
                        jumpmux    = jump_i;
                        branchmux  = br_taken & ~jump_i;
                    end else if (ihit) begin
                        // Stale instruction returned and is discarded
                        state_d = FETCH;
                    end
                end

                HALT: begin
                    state_d = HALT;
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign halted = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic missInc;
    logic squashInc;

    // A miss is a FETCH cycle with an active read and no instruction back.
    // A squash is any instruction returning while in SQUASH, including one
    // that arrives together with a further redirect. HALT freezes both.
    assign missInc   = run_q & (state_q == FETCH) & ~ihit;
    assign squashInc = run_q & (state_q == SQUASH) & ihit & ~halt_i;

    fetch_perf_ctr #(.CNT_W(CNT_W)) u_miss_ctr (
        .CLK   (CLK),
        .nRST  (nRST),
        .en_i  (missInc),
        .cnt_o (miss_cnt)
    );

    fetch_perf_ctr #(.CNT_W(CNT_W)) u_squash_ctr (
        .CLK   (CLK),
        .nRST  (nRST),
        .en_i  (squashInc),
        .cnt_o (squash_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A table of {reset, inputs, expected
// outputs, expected counters} records is replayed through a scoreboard queue,
// followed by hand-written multi-cycle sequences.
// Configuration macro: FETCH_PERF_EN (enables counter checks)
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0;
    logic stall_i = 1'b0;
    logic br_taken = 1'b0;
    logic jump_i = 1'b0;
    logic halt_i = 1'b0;
    logic pcEN, branchmux, jumpmux, imemREN, ifid_en, ifid_flush, halted;
`ifdef FETCH_PERF_EN
    logic [31:0] miss_cnt, squash_cnt;
`endif

    always #5 CLK = ~CLK;

    fetch_ctrl dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .stall_i    (stall_i),
        .br_taken   (br_taken),
        .jump_i     (jump_i),
        .halt_i     (halt_i),
        .pcEN       (pcEN),
        .branchmux  (branchmux),
        .jumpmux    (jumpmux),
        .imemREN    (imemREN),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
`ifdef FETCH_PERF_EN
        .miss_cnt   (miss_cnt),
        .squash_cnt (squash_cnt),
`endif
        .halted     (halted)
    );

    // stim   = {ihit, stall_i, br_taken, jump_i, halt_i}
    // expOut = {pcEN, branchmux, jumpmux, imemREN, ifid_en, ifid_flush, halted}
    typedef struct {
        logic        rstN;
        logic [4:0]  stim;
        logic [6:0]  expOut;
        int unsigned expMiss;
        int unsigned expSquash;
        logic        chkCnt;
    } vec_t;

    vec_t tbl[$];
    vec_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Output patterns used throughout the table
    localparam logic [6:0] O_ZERO = 7'b000_0000;
    localparam logic [6:0] O_RUN  = 7'b100_1100;
    localparam logic [6:0] O_WAIT = 7'b000_1000;
    localparam logic [6:0] O_BR   = 7'b110_1010;
    localparam logic [6:0] O_JMP  = 7'b101_1010;
    localparam logic [6:0] O_HLT  = 7'b000_0001;

    task automatic addVec(input logic r, input logic [4:0] s, input logic [6:0] e,
                          input int unsigned m, input int unsigned q, input logic c);
        vec_t v;
        v.rstN = r; v.stim = s; v.expOut = e;
        v.expMiss = m; v.expSquash = q; v.chkCnt = c;
        tbl.push_back(v);
    endtask

    // Drive a record away from the active edge and queue what it must produce
    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        nRST = v.rstN;
        {ihit, stall_i, br_taken, jump_i, halt_i} = v.stim;
        expQ.push_back(v);
    endtask

    // Compare the DUT against the oldest queued expectation
    task automatic checkOutput(input string name);
        vec_t e;
        logic [6:0] act;
        #2;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard empty", name);
            return;
        end
        e = expQ.pop_front();
        act = {pcEN, branchmux, jumpmux, imemREN, ifid_en, ifid_flush, halted};
        if (act !== e.expOut) begin
            errors++;
            $display("[TB] FAIL %s outputs got %b expected %b", name, act, e.expOut);
        end
`ifdef FETCH_PERF_EN
        if (e.chkCnt) begin
            checks++;
            if (miss_cnt !== e.expMiss) begin
                errors++;
                $display("[TB] FAIL %s miss_cnt got %0d expected %0d", name, miss_cnt, e.expMiss);
            end
            checks++;
            if (squash_cnt !== e.expSquash) begin
                errors++;
                $display("[TB] FAIL %s squash_cnt got %0d expected %0d", name, squash_cnt, e.expSquash);
            end
        end
`endif
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(name);
    endtask

    initial begin
        vec_t v;
        // Reset, then first cycle after release is quiet, then free-running
        addVec(1'b0, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  0, 0, 1'b1);
        // Three icache wait cycles
        addVec(1'b1, 5'b00000, O_WAIT, 0, 0, 1'b1);
        addVec(1'b1, 5'b00000, O_WAIT, 1, 0, 1'b1);
        addVec(1'b1, 5'b00000, O_WAIT, 2, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  3, 0, 1'b1);
        // Stall, then branch overriding the stall
        addVec(1'b1, 5'b11000, O_WAIT, 3, 0, 1'b1);
        addVec(1'b1, 5'b11100, O_BR,   3, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  3, 0, 1'b1);
        // Jump with fetch in flight -> SQUASH, stale hit discarded
        addVec(1'b1, 5'b00010, O_JMP,  3, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_WAIT, 4, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  4, 1, 1'b1);
        // Branch and jump together: jump wins
        addVec(1'b1, 5'b10110, O_JMP,  4, 1, 1'b1);
        // Branch without hit -> SQUASH, jump while squashing, idle squash
        addVec(1'b1, 5'b00100, O_BR,   4, 1, 1'b1);
        addVec(1'b1, 5'b00010, O_JMP,  5, 1, 1'b1);
        addVec(1'b1, 5'b00000, O_WAIT, 5, 1, 1'b1);
        // Halt during SQUASH, inputs ignored, counters frozen
        addVec(1'b1, 5'b00001, O_WAIT, 5, 1, 1'b1);
        addVec(1'b1, 5'b10110, O_HLT,  5, 1, 1'b1);
        addVec(1'b1, 5'b00000, O_HLT,  5, 1, 1'b1);
        // Reset pulse leaves HALT
        addVec(1'b0, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  0, 0, 1'b1);
        // Reset while in SQUASH returns to FETCH with nothing pending
        addVec(1'b1, 5'b00010, O_JMP,  0, 0, 1'b1);
        addVec(1'b0, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_ZERO, 0, 0, 1'b1);
        addVec(1'b1, 5'b10000, O_RUN,  0, 0, 1'b1);

        $display("[TB] replaying %0d table vectors", tbl.size());
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], $sformatf("vec%0d", i));
        end

        // ihit and redirect together in SQUASH: stay in SQUASH
        v.rstN = 1'b1; v.chkCnt = 1'b0; v.expMiss = 0; v.expSquash = 0;
        v.stim = 5'b00010; v.expOut = O_JMP;  runVec(v, "sq_enter");
        v.stim = 5'b10100; v.expOut = O_BR;   runVec(v, "sq_hit_redirect");
        v.stim = 5'b00000; v.expOut = O_WAIT; runVec(v, "sq_still_pending");
        v.stim = 5'b10000; v.expOut = O_WAIT; runVec(v, "sq_discard");
        v.stim = 5'b10000; v.expOut = O_RUN;  runVec(v, "sq_back_fetch");

        // Halt from FETCH, then random inputs must not disturb HALT
        v.stim = 5'b00001; v.expOut = O_WAIT; runVec(v, "halt_enter");
        for (int i = 0; i < 16; i++) begin
            v.stim = 5'($urandom_range(0, 31));
            v.expOut = O_HLT;
            runVec(v, $sformatf("halt_sticky%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
